fir_coef_reload_ctrl: RTL and testbench

Sequences run-time coefficient reloads into the fir91 reloadable-coefficient FIR core. It streams a coefficient set from a synchronous coefficient ROM/RAM into the core's inactive bank (coef_set_in, coef_we, coef_in). It then flips the core's active bank (coef_set) only in an input idle gap, so no sample is filtered with a half-written set. It sits between the host/config logic and the FIR core; the FIR's Avalon-ST data path passes through untouched.

---
 rtl/fir_coef_reload_ctrl_if.sv | 31 +++
 rtl/fir_coef_reload_ctrl.sv | 101 ++++++++++
 tb/tb_fir_coef_reload_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_reload_ctrl_if.sv
// rtl/fir_coef_reload_ctrl_if.sv - load request, coefficient memory and FIR core coefficient bus
interface fir_coef_reload_ctrl_if #(
  parameter int COEF_WIDTH = 19,
  parameter int ADDR_WIDTH = 8
);
  logic                  load_req;
  logic [ADDR_WIDTH-1:0] load_base;
  logic                  load_ready;
  logic                  busy;
  logic                  swap_done;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [COEF_WIDTH-1:0] mem_rd_data;
  logic                  ast_sink_valid;
  logic                  coef_set;
  logic                  coef_set_in;
  logic                  coef_we;
  logic [COEF_WIDTH-1:0] coef_in;

  modport master (
    output load_req, load_base, mem_rd_data, ast_sink_valid,
    input  load_ready, busy, swap_done, mem_rd_en, mem_rd_addr,
           coef_set, coef_set_in, coef_we, coef_in
  );

  modport slave (
    input  load_req, load_base, mem_rd_data, ast_sink_valid,
    output load_ready, busy, swap_done, mem_rd_en, mem_rd_addr,
           coef_set, coef_set_in, coef_we, coef_in
  );
endinterface

// File: rtl/fir_coef_reload_ctrl.sv
// rtl/fir_coef_reload_ctrl.sv - streams a coefficient set into the inactive FIR bank, then swaps banks in an input idle gap
module fir_coef_reload_ctrl #(
  parameter int COEF_WIDTH = 19,
  parameter int NUM_COEF   = 80,
  parameter int ADDR_WIDTH = 8,
  parameter int SWAP_IDLE  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  fir_coef_reload_ctrl_if.slave   bus
);
  localparam int CNT_W  = $clog2(NUM_COEF + 1);
  localparam int IDLE_W = $clog2(SWAP_IDLE + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, SWAP_WAIT} state_t;

  state_t                state;
  logic [CNT_W-1:0]      k_cnt;
  logic [IDLE_W-1:0]     idle_cnt;
  logic [IDLE_W-1:0]     idle_nxt;
  logic                  rd_valid;
  logic [COEF_WIDTH-1:0] coef_hold;

  // Saturating run length of consecutive idle input cycles, including this one.
  always_comb begin
    idle_nxt = '0;
    if (!bus.ast_sink_valid) begin
      if (idle_cnt == IDLE_W'(SWAP_IDLE)) idle_nxt = idle_cnt;
      else                                idle_nxt = idle_cnt + 1'b1;
    end
  end

  // Memory data is passed straight to the core in the cycle it is valid so the
  // core sees coefficient k one cycle after its write strobe; otherwise hold.
  assign bus.coef_in = rd_valid ? bus.mem_rd_data : coef_hold;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      k_cnt           <= '0;
      idle_cnt        <= '0;
      rd_valid        <= 1'b0;
      coef_hold       <= '0;
      bus.load_ready  <= 1'b1;
      bus.busy        <= 1'b0;
      bus.swap_done   <= 1'b0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_rd_addr <= '0;
      bus.coef_set    <= 1'b0;
      bus.coef_set_in <= 1'b1;
      bus.coef_we     <= 1'b0;
    end else begin
      bus.swap_done <= 1'b0;
      rd_valid      <= bus.mem_rd_en;
      if (rd_valid) coef_hold <= bus.mem_rd_data;

      case (state)
        IDLE: begin
          if (bus.load_req && bus.load_ready) begin
            bus.mem_rd_addr <= bus.load_base;
            bus.coef_set_in <= ~bus.coef_set;
            bus.mem_rd_en   <= 1'b1;
            bus.coef_we     <= 1'b1;
            bus.busy        <= 1'b1;
            bus.load_ready  <= 1'b0;
            k_cnt           <= '0;
            idle_cnt        <= '0;
            state           <= READ;
          end
        end
        READ: begin
          if (k_cnt == CNT_W'(NUM_COEF - 1)) begin
            bus.mem_rd_en <= 1'b0;
            bus.coef_we   <= 1'b0;
            state         <= DRAIN;
          end else begin
            k_cnt           <= k_cnt + 1'b1;
            bus.mem_rd_addr <= bus.mem_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          idle_cnt <= idle_nxt;
          state    <= SWAP_WAIT;
        end
        SWAP_WAIT: begin
          if (idle_nxt >= IDLE_W'(SWAP_IDLE)) begin
            bus.coef_set   <= ~bus.coef_set;
            bus.swap_done  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.load_ready <= 1'b1;
            idle_cnt       <= '0;
            state          <= IDLE;
          end else begin
            idle_cnt <= idle_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_coef_reload_ctrl.sv
// tb/tb_fir_coef_reload_ctrl.sv - self-checking bench for fir_coef_reload_ctrl
module tb_fir_coef_reload_ctrl;
  localparam int CW = 19;
  localparam int N  = 80;
  localparam int AW = 8;
  localparam int SI = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fir_coef_reload_ctrl_if #(.COEF_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

  fir_coef_reload_ctrl #(
    .COEF_WIDTH(CW), .NUM_COEF(N), .ADDR_WIDTH(AW), .SWAP_IDLE(SI)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous coefficient memory: data one cycle after the read strobe.
  logic [CW-1:0] mem [0:255];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a load is a time window measured from its acceptance edge.
  int cyc = 0;
  int off;
  bit m_known = 0, m_busy = 0, m_set = 0, m_set_in = 1;
  int m_t0 = 0, m_base = 0, m_run = 0, m_swap_c = -1;
  longint m_coef = 0;
  bit exp_we;
  longint exp_coef;

  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        off = cyc - m_t0;
        exp_we = m_busy && off >= 1 && off <= N;
        chk("load_ready", bus.load_ready, !m_busy);
        chk("busy", bus.busy, m_busy);
        chk("swap_done", bus.swap_done, cyc == m_swap_c);
        chk("coef_set", bus.coef_set, m_set);
        if (m_busy) chk("coef_set_in", bus.coef_set_in, m_set_in);
        chk("coef_we", bus.coef_we, exp_we);
        chk("mem_rd_en", bus.mem_rd_en, exp_we);
        if (exp_we) chk("mem_rd_addr", bus.mem_rd_addr, (m_base + off - 1) % 256);
        exp_coef = (m_busy && off >= 2 && off <= N + 1) ? mem[(m_base + off - 2) % 256] : m_coef;
        chk("coef_in", bus.coef_in, exp_coef);
      end
      if (!reset_n) begin
        m_known = 1; m_busy = 0; m_set = 0; m_set_in = 1; m_coef = 0; m_swap_c = -1;
      end else if (m_known) begin
        if (m_busy) begin
          off = cyc - m_t0;
          if (off == N + 1) m_coef = mem[(m_base + N - 1) % 256];
          if (off >= N + 1) m_run = bus.ast_sink_valid ? 0 : m_run + 1;
          if (off >= N + 2 && m_run >= SI) begin
            m_set = !m_set; m_busy = 0; m_swap_c = cyc + 1;
          end
        end else if (bus.load_req) begin
          m_busy = 1; m_t0 = cyc; m_base = int'(bus.load_base); m_set_in = !m_set; m_run = 0;
        end
      end
      cyc++;
    end
  end

  // Per-load observations, indexed by cycle relative to the request cycle.
  int r_we, r_swap, r_first, r_drain, r_si, r_rstc, r_set;
  int r_a [4];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      bus.load_req = 1'b0;
      bus.ast_sink_valid = 1'b0;
    end
  endtask

  // mode 0: input idle; mode 1: valid until 50 cycles after DRAIN with a lone
  // idle gap; mode 2: extra load_req pulses while busy. Called at posedge+2.
  task automatic run_load(input int base, input int mode, input int rst_rel);
    r_we = 0; r_swap = -1; r_first = -1; r_drain = -1; r_si = -1; r_rstc = -1; r_set = -1;
    for (int i = 0; i < 4; i++) r_a[i] = -1;
    for (int rel = 0; rel < 400; rel++) begin
      bus.load_req = (rel == 0) || (mode == 2 && (rel == 10 || rel == 40 || rel == 82));
      bus.load_base = (rel == 0) ? AW'(base) : AW'(5);
      bus.ast_sink_valid = (mode == 1) && (rel <= 131 || (rel >= 133 && rel <= 136));
      if (rst_rel >= 0 && rel >= rst_rel) reset_n = 1'b0;
      @(negedge clk);
      if (bus.coef_we) begin
        if (r_we == 0)  r_a[0] = int'(bus.mem_rd_addr);
        if (r_we == 55) r_a[1] = int'(bus.mem_rd_addr);
        if (r_we == 56) r_a[2] = int'(bus.mem_rd_addr);
        if (r_we == 79) r_a[3] = int'(bus.mem_rd_addr);
        r_we++;
      end
      if (rel == 2) r_first = int'(bus.coef_in);
      if (rel == N + 1) begin
        r_drain = int'(bus.coef_in);
        r_si = int'(bus.coef_set_in);
      end
      if (rel == rst_rel) r_rstc = int'(bus.coef_in);
      if (bus.swap_done) begin
        r_swap = rel;
        r_set = int'(bus.coef_set);
        break;
      end
      if (rst_rel >= 0 && rel == rst_rel + 1) break;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = CW'(a + 84);
    bus.load_req = 1'b0;
    bus.load_base = '0;
    bus.ast_sink_valid = 1'b0;
    reset_n = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("rst_coef_set", bus.coef_set, 0);
    chk("rst_coef_set_in", bus.coef_set_in, 1);
    chk("rst_coef_we", bus.coef_we, 0);
    chk("rst_load_ready", bus.load_ready, 1);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    idle(2);

    run_load(16, 0, -1);
    chk("basic_we_cnt", r_we, 80);
    chk("basic_first", r_first, 100);
    chk("basic_drain", r_drain, 179);
    chk("basic_set_in", r_si, 1);
    chk("basic_swap_rel", r_swap, 83);
    chk("basic_set", r_set, 1);
    idle(3);

    run_load(96, 0, -1);
    chk("pp_we_cnt", r_we, 80);
    chk("pp_first", r_first, 180);
    chk("pp_drain", r_drain, 259);
    chk("pp_set_in", r_si, 0);
    chk("pp_swap_rel", r_swap, 83);
    chk("pp_set", r_set, 0);
    idle(3);

    run_load(16, 1, -1);
    chk("defer_we_cnt", r_we, 80);
    chk("defer_swap_rel", r_swap, 139);
    chk("defer_set", r_set, 1);
    idle(3);

    run_load(16, 0, 42);
    chk("midrst_coef40", r_rstc, 140);
    chk("midrst_coef_set", bus.coef_set, 0);
    chk("midrst_coef_we", bus.coef_we, 0);
    chk("midrst_rd_en", bus.mem_rd_en, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.load_ready, 1);
    chk("midrst_coef_in", bus.coef_in, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    idle(2);

    run_load(16, 0, -1);
    chk("fresh_first", r_first, 100);
    chk("fresh_swap_rel", r_swap, 83);
    chk("fresh_set", r_set, 1);
    idle(3);

    run_load(200, 2, -1);
    chk("wrap_we_cnt", r_we, 80);
    chk("wrap_addr_k0", r_a[0], 200);
    chk("wrap_addr_k55", r_a[1], 255);
    chk("wrap_addr_k56", r_a[2], 0);
    chk("wrap_addr_k79", r_a[3], 23);
    chk("wrap_swap_rel", r_swap, 83);
    chk("wrap_set", r_set, 0);
    idle(3);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
